// File: rtl/pipeline_control_unit.sv
// Pipeline sequencing controller: run / single-step / halt-drain FSM driving the
// PC, IF/ID and back-end register enables, plus a saturating active-cycle counter.
module pipeline_control_unit #(
  parameter int DRAIN_CYCLES = 4,
  parameter int N_BITS_CNT   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode_step,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic                  i_halt_id,
  output logic                  o_pc_we,
  output logic                  o_ifid_we,
  output logic                  o_ifid_flush,
  output logic                  o_idex_bubble,
  output logic                  o_pipe_en,
  output logic                  o_running,
  output logic                  o_halted,
  output logic                  o_step_done,
  output logic [N_BITS_CNT-1:0] o_cycle_count
);

  // state      | meaning
  // IDLE       | waiting for i_start, pipeline frozen
  // RUN        | continuous execution
  // STEP_WAIT  | step mode, frozen until an i_step rising edge
  // STEP_EXEC  | one-cycle step, pipeline advances
  // DRAIN      | HALT fetched, bubbles pushed until back end empties
  // HALTED     | terminal, left only by reset

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP_WAIT,
    ST_STEP_EXEC,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  state_t                state, state_nxt;
  logic [DW-1:0]         drain_cnt, drain_cnt_nxt;
  logic                  step_prev;
  logic                  step_rise;
  logic [N_BITS_CNT-1:0] cycle_cnt;

  // Edge detect so a held i_step yields only one step.
  assign step_rise = i_step & ~step_prev;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      step_prev <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      step_prev <= i_step;
      if (o_pipe_en && (cycle_cnt != {N_BITS_CNT{1'b1}})) begin
        cycle_cnt <= cycle_cnt + N_BITS_CNT'(1);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    o_pipe_en     = 1'b0;
    o_running     = 1'b0;
    o_halted      = 1'b0;
    o_step_done   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt = i_mode_step ? ST_STEP_WAIT : ST_RUN;
        end
      end

      ST_RUN, ST_STEP_EXEC: begin
        o_pipe_en     = 1'b1;
        o_running     = 1'b1;
        o_pc_we       = ~i_stall & ~i_halt_id;
        o_ifid_we     = ~i_stall;
        o_idex_bubble = i_stall;
        o_ifid_flush  = ~i_stall & (i_branch_taken | i_halt_id);
        o_step_done   = (state == ST_STEP_EXEC);
        // A stalled HALT is held off and re-evaluated once the stall clears.
        if (i_halt_id && !i_stall) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end else if (state == ST_STEP_EXEC) begin
          state_nxt = ST_STEP_WAIT;
        end
      end

      ST_STEP_WAIT: begin
        if (step_rise) begin
          state_nxt = ST_STEP_EXEC;
        end
      end

      ST_DRAIN: begin
        o_pipe_en     = 1'b1;
        o_running     = 1'b1;
        o_idex_bubble = 1'b1;
        if (drain_cnt == '0) begin
          state_nxt = ST_HALTED;
        end else begin
          drain_cnt_nxt = drain_cnt - DW'(1);
        end
      end

      ST_HALTED: begin
        o_halted = 1'b1;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_cycle_count = cycle_cnt;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: per-cycle expected control vectors
// are queued as stimulus is applied and compared against captured outputs.
module tb_pipeline_control_unit;

  logic i_clock = 1'b0;
  logic i_reset, i_start, i_mode_step, i_step, i_stall, i_branch_taken, i_halt_id;
  logic o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble, o_pipe_en;
  logic o_running, o_halted, o_step_done;
  logic [31:0] o_cycle_count;
  logic s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble, s_pipe_en;
  logic s_running, s_halted, s_step_done;
  logic [3:0] s_cycle_count;
  logic [7:0] ctrl_obs;

  pipeline_control_unit #(.DRAIN_CYCLES(4), .N_BITS_CNT(32)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_mode_step(i_mode_step),
    .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_halt_id(i_halt_id),
    .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we), .o_ifid_flush(o_ifid_flush),
    .o_idex_bubble(o_idex_bubble), .o_pipe_en(o_pipe_en), .o_running(o_running),
    .o_halted(o_halted), .o_step_done(o_step_done), .o_cycle_count(o_cycle_count)
  );

  pipeline_control_unit #(.DRAIN_CYCLES(4), .N_BITS_CNT(4)) dut_sat (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_mode_step(i_mode_step),
    .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_halt_id(i_halt_id),
    .o_pc_we(s_pc_we), .o_ifid_we(s_ifid_we), .o_ifid_flush(s_ifid_flush),
    .o_idex_bubble(s_idex_bubble), .o_pipe_en(s_pipe_en), .o_running(s_running),
    .o_halted(s_halted), .o_step_done(s_step_done), .o_cycle_count(s_cycle_count)
  );

  always #5 i_clock = ~i_clock;

  assign ctrl_obs = {o_pc_we, o_ifid_we, o_ifid_flush, o_idex_bubble,
                     o_pipe_en, o_running, o_halted, o_step_done};

  // Input vector: {reset, start, mode_step, step, stall, branch, halt}
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_RST   = 7'b1000000;
  localparam logic [6:0] I_START = 7'b0100000;
  localparam logic [6:0] I_SMODE = 7'b0010000;
  localparam logic [6:0] I_STEP  = 7'b0001000;
  localparam logic [6:0] I_STALL = 7'b0000100;
  localparam logic [6:0] I_BR    = 7'b0000010;
  localparam logic [6:0] I_HALT  = 7'b0000001;

  // Control vector: {pc_we, ifid_we, flush, bubble, pipe_en, running, halted, step_done}
  localparam logic [7:0] C_IDLE   = 8'b00000000;
  localparam logic [7:0] C_RUN    = 8'b11001100;
  localparam logic [7:0] C_STALL  = 8'b00011100;
  localparam logic [7:0] C_BR     = 8'b11101100;
  localparam logic [7:0] C_HALT   = 8'b01101100;
  localparam logic [7:0] C_DRAIN  = 8'b00011100;
  localparam logic [7:0] C_HALTED = 8'b00000010;
  localparam logic [7:0] C_EXEC   = 8'b11001101;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] cnt;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        obs_q[$];
  string       tag_q[$];
  logic [31:0] exp_cnt = 0;
  int          passed = 0;
  int          total  = 0;

  // Drives one cycle of stimulus, queues the expectation and captures the DUT at negedge.
  task automatic apply(input logic [6:0] in_v, input logic [7:0] ctrl_e, input string tag);
    {i_reset, i_start, i_mode_step, i_step, i_stall, i_branch_taken, i_halt_id} = in_v;
    exp_q.push_back('{ctrl: ctrl_e, cnt: exp_cnt});
    tag_q.push_back(tag);
    @(negedge i_clock);
    obs_q.push_back('{ctrl: ctrl_obs, cnt: o_cycle_count});
    @(posedge i_clock);
    #1;
    if (in_v[6]) exp_cnt = 0;
    else if (ctrl_e[3] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
  endtask

  task automatic do_reset();
    {i_reset, i_start, i_mode_step, i_step, i_stall, i_branch_taken, i_halt_id} = I_RST;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    rec_t e, o;
    string t;
    do_reset();
    total++;
    if (ctrl_obs !== C_IDLE) $display("FAIL reset_ctrl got %b exp %b", ctrl_obs, C_IDLE);
    else passed++;
    total++;
    if (s_cycle_count !== 4'd0) $display("FAIL reset_sat_cnt got %0d exp 0", s_cycle_count);
    else passed++;
    apply(I_STEP, C_IDLE, "idle_step_ignored");
    apply(I_STALL | I_BR | I_HALT, C_IDLE, "idle_frozen");
    apply(I_NONE, C_IDLE, "idle_stays");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_run();
    rec_t e, o;
    string t;
    apply(I_START, C_IDLE, "run_start");
    for (int i = 0; i < 10; i++) apply(I_NONE, C_RUN, $sformatf("run_%0d", i));
    apply(I_START, C_RUN, "run_cnt10_start_ignored");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_stall_branch();
    rec_t e, o;
    string t;
    apply(I_STALL | I_BR, C_STALL, "stall_over_branch");
    apply(I_BR, C_BR, "branch_flush");
    apply(I_STALL, C_STALL, "stall_only");
    apply(I_NONE, C_RUN, "run_resume");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_halt_drain();
    rec_t e, o;
    string t;
    apply(I_HALT, C_HALT, "halt_in_id");
    apply(I_NONE, C_DRAIN, "drain_1");
    apply(I_STEP, C_DRAIN, "drain_2_step_ignored");
    apply(I_START | I_BR, C_DRAIN, "drain_3");
    apply(I_NONE, C_DRAIN, "drain_4");
    apply(I_NONE, C_HALTED, "halted");
    apply(I_START, C_HALTED, "halted_start_ignored");
    apply(I_STEP | I_SMODE | I_START, C_HALTED, "halted_terminal");
    apply(I_NONE, C_HALTED, "halted_cnt_frozen");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_step_mode();
    rec_t e, o;
    string t;
    int done_pulses = 0;
    do_reset();
    apply(I_START | I_SMODE, C_IDLE, "step_start");
    apply(I_STEP, C_IDLE, "sw_pulse1");
    apply(I_NONE, C_EXEC, "exec1");
    for (int i = 0; i < 3; i++) apply(I_NONE, C_IDLE, "sw_wait_a");
    apply(I_STEP, C_IDLE, "sw_held_1");
    apply(I_STEP, C_EXEC, "exec2_held_2");
    apply(I_STEP, C_IDLE, "sw_held_3_ignored");
    apply(I_NONE, C_IDLE, "sw_wait_b");
    apply(I_NONE, C_IDLE, "sw_wait_c");
    apply(I_STEP, C_IDLE, "sw_pulse3");
    apply(I_NONE, C_EXEC, "exec3");
    apply(I_NONE, C_IDLE, "sw_cnt3");
    apply(I_START, C_IDLE, "sw_start_ignored");
    apply(I_STEP, C_IDLE, "sw_pulse4");
    apply(I_RST, C_EXEC, "exec_reset");
    apply(I_NONE, C_IDLE, "idle_after_exec_reset");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      if (o.ctrl[0] === 1'b1 && t != "exec_reset") done_pulses++;
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
    total++;
    if (done_pulses !== 3) $display("FAIL step_done_pulses got %0d exp 3", done_pulses);
    else passed++;
  endtask

  task automatic test_stall_halt();
    rec_t e, o;
    string t;
    do_reset();
    apply(I_START, C_IDLE, "sh_start");
    apply(I_NONE, C_RUN, "sh_run");
    apply(I_STALL | I_HALT, C_STALL, "sh_stalled_1");
    apply(I_STALL | I_HALT, C_STALL, "sh_stalled_2");
    apply(I_HALT, C_HALT, "sh_release");
    for (int i = 0; i < 4; i++) apply(I_NONE, C_DRAIN, $sformatf("sh_drain_%0d", i));
    apply(I_NONE, C_HALTED, "sh_halted");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_drain();
    rec_t e, o;
    string t;
    do_reset();
    apply(I_START, C_IDLE, "rd_start");
    apply(I_NONE, C_RUN, "rd_run");
    apply(I_HALT, C_HALT, "rd_halt");
    apply(I_NONE, C_DRAIN, "rd_drain_1");
    apply(I_RST | I_STEP, C_DRAIN, "rd_drain_2_reset");
    apply(I_NONE, C_IDLE, "rd_idle_cnt0");
    apply(I_NONE, C_IDLE, "rd_idle_hold");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  task automatic test_saturation();
    rec_t e, o;
    string t;
    do_reset();
    apply(I_START, C_IDLE, "sat_start");
    for (int i = 0; i < 10; i++) apply(I_NONE, C_RUN, "sat_run_a");
    total++;
    if (s_cycle_count !== 4'd10) $display("FAIL sat_cnt10 got %0d exp 10", s_cycle_count);
    else passed++;
    for (int i = 0; i < 10; i++) apply(I_NONE, C_RUN, "sat_run_b");
    total++;
    if (s_cycle_count !== 4'd15) $display("FAIL sat_cnt20 got %0d exp 15", s_cycle_count);
    else passed++;
    total++;
    if (o_cycle_count !== 32'd20) $display("FAIL wide_cnt20 got %0d exp 20", o_cycle_count);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      total++;
      if (o.ctrl !== e.ctrl) $display("FAIL %s ctrl got %b exp %b", t, o.ctrl, e.ctrl);
      else passed++;
      total++;
      if (o.cnt !== e.cnt) $display("FAIL %s count got %0d exp %0d", t, o.cnt, e.cnt);
      else passed++;
    end
  endtask

  initial begin
    {i_reset, i_start, i_mode_step, i_step, i_stall, i_branch_taken, i_halt_id} = I_RST;
    @(posedge i_clock);
    test_reset();
    test_run();
    test_stall_branch();
    test_halt_drain();
    test_step_mode();
    test_stall_halt();
    test_reset_mid_drain();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
